// File: rtl/uart_rx_param.sv
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver with glitch rejection, parity/framing
//            error flags and one-cycle completion strobe. Optional macro
//            UART_RX_MAJORITY_EN selects 3-sample majority voting.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_param #(
    parameter int         CLKS_PER_BIT = 27,
    parameter int         DATA_BITS    = 8,
    parameter int         MSB_FIRST    = 1,
    parameter int         PARITY_MODE  = 1,
    parameter int         STOP_BITS    = 1,
    parameter logic [8:0] ERR_CHAR     = 9'h03F
) (
    input  logic                 clk_3125,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_msg,
    output logic                 rx_parity,
    output logic                 rx_complete,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_AT = HALF + 1;
`else
    localparam int SAMPLE_AT = HALF;
`endif

    localparam logic [CW-1:0] c_sample_at = CW'(SAMPLE_AT);
    localparam logic [CW-1:0] c_bit_end   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] c_last_bit  = BW'(DATA_BITS - 1);
    localparam logic          c_last_stop = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_start   = 3'd1;
    localparam logic [2:0] c_data    = 3'd2;
    localparam logic [2:0] c_parity  = 3'd3;
    localparam logic [2:0] c_stop    = 3'd4;
    localparam logic [2:0] c_wait_hi = 3'd5;

    logic [2:0]           r_state;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_stop_bad;
    logic                 r_par;
    logic [DATA_BITS-1:0] r_data;

    logic                 w_sample;
    logic                 w_bit_tick;
    logic [DATA_BITS-1:0] w_data_next;
    logic                 w_parity_calc;
    logic                 w_parity_err;
    logic                 w_frame_err;

`ifdef UART_RX_MAJORITY_EN
    // r_hist[0] holds rx_s one cycle back, r_hist[1] two cycles back
    logic [1:0] r_hist;

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_sample = (r_rx_s & r_hist[0]) | (r_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign w_sample = r_rx_s;
`endif

    assign w_bit_tick = (r_clk_cnt == c_bit_end);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_data_next = {r_data[DATA_BITS-2:0], w_sample};
        end else begin : g_lsb_first
            assign w_data_next = {w_sample, r_data[DATA_BITS-1:1]};
        end
    endgenerate

    assign w_parity_calc = (^r_data) ^ r_par;

    generate
        if (PARITY_MODE == 0) begin : g_no_parity
            assign w_parity_err = 1'b0;
        end else if (PARITY_MODE == 2) begin : g_odd_parity
            assign w_parity_err = ~w_parity_calc;
        end else begin : g_even_parity
            assign w_parity_err = w_parity_calc;
        end
    endgenerate

    assign w_frame_err = r_stop_bad | ~w_sample;

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
            r_stop_bad  <= 1'b0;
            r_par       <= 1'b0;
            r_data      <= '0;
            rx_msg      <= '0;
            rx_parity   <= 1'b0;
            rx_complete <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_rx_s      <= r_sync1;
            rx_complete <= 1'b0;

            case (r_state)
                c_idle: begin
                    if (!r_rx_s) begin
                        r_state   <= c_start;
                        r_clk_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end

                c_start: begin
                    if (r_clk_cnt == c_sample_at) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        if (w_sample) begin
                            r_state <= c_idle;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= c_data;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                c_data: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_data    <= w_data_next;
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt  <= '0;
                            r_stop_cnt <= 1'b0;
                            r_stop_bad <= 1'b0;
                            r_state    <= (PARITY_MODE != 0) ? c_parity : c_stop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                c_parity: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_par     <= w_sample;
                        r_state   <= c_stop;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                c_stop: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        if (r_stop_cnt == c_last_stop) begin
                            rx_complete <= 1'b1;
                            rx_parity   <= r_par;
                            parity_err  <= w_parity_err;
                            frame_err   <= w_frame_err;
                            rx_msg      <= (w_parity_err | w_frame_err) ?
                                           ERR_CHAR[DATA_BITS-1:0] : r_data;
                            // a low stop bit may be a line break: wait for idle before rearming
                            r_state     <= w_frame_err ? c_wait_hi : c_idle;
                            busy        <= w_frame_err;
                        end else begin
                            r_stop_cnt <= 1'b1;
                            r_stop_bad <= r_stop_bad | ~w_sample;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                c_wait_hi: begin
                    if (r_rx_s) begin
                        r_state <= c_idle;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_idle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Directed scoreboard bench for uart_rx_param at default parameters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_param;

    localparam int CPB    = 27;
    localparam int N_BITS = 11;   // start + 8 data + even parity + 1 stop
`ifdef UART_RX_MAJORITY_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] msg;
        logic       par;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk_3125 = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   strobe_cnt = 0;
    int   strobe_times[$];
    exp_t sb[$];
    logic prev_complete = 1'b0;

    uart_rx_param dut (
        .clk_3125    (clk_3125),
        .rst         (rst),
        .rx          (rx),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .rx_complete (rx_complete),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk_3125 = ~clk_3125;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every strobe pops one expected word
    always @(negedge clk_3125) begin
        exp_t e;
        cycle++;
        if (rx_complete) begin
            strobe_cnt++;
            strobe_times.push_back(cycle);
            check("strobe_width", {8'h0, prev_complete}, 9'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_strobe: observed rx_msg=%h expected no strobe", rx_msg);
            end else begin
                e = sb.pop_front();
                check("rx_msg",     {1'b0, rx_msg},     {1'b0, e.msg});
                check("rx_parity",  {8'h0, rx_parity},  {8'h0, e.par});
                check("parity_err", {8'h0, parity_err}, {8'h0, e.perr});
                check("frame_err",  {8'h0, frame_err},  {8'h0, e.ferr});
            end
        end
        prev_complete = rx_complete;
    end

    task automatic send_bit(input logic b, input bit g);
        rx = b;
        if (g) begin
            repeat (15) @(negedge clk_3125);
            rx = ~b;
            @(negedge clk_3125);
            rx = b;
            repeat (CPB - 16) @(negedge clk_3125);
        end else begin
            repeat (CPB) @(negedge clk_3125);
        end
    endtask

    // Stop bit is never disturbed so that the next start edge is seen cleanly
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_v, input bit g);
        send_bit(1'b0, g);
        for (int i = 7; i >= 0; i--) send_bit(d[i], g);
        send_bit(p, g);
        send_bit(stop_v, 1'b0);
    endtask

    task automatic push(input logic [7:0] m, input logic p, input logic pe, input logic fe);
        exp_t e;
        e.msg  = m;
        e.par  = p;
        e.perr = pe;
        e.ferr = fe;
        sb.push_back(e);
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobe_cnt < target && n < 3000) begin
            @(negedge clk_3125);
            n++;
        end
        checks++;
        assert (strobe_cnt >= target) else begin
            errors++;
            $error("FAIL strobe_timeout: observed %0d strobes expected %0d", strobe_cnt, target);
        end
    endtask

    initial begin
        int base;
        int gap;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk_3125);
        check("rst_msg",    {1'b0, rx_msg}, 9'h0);
        check("rst_par",    {8'h0, rx_parity}, 9'h0);
        check("rst_cmpl",   {8'h0, rx_complete}, 9'h0);
        check("rst_perr",   {8'h0, parity_err}, 9'h0);
        check("rst_ferr",   {8'h0, frame_err}, 9'h0);
        check("rst_busy",   {8'h0, busy}, 9'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk_3125);

        // Good frame
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        wait_strobes(1);
        repeat (10) @(negedge clk_3125);
        check("busy_after_ok", {8'h0, busy}, 9'h0);

        // Bad parity
        push(8'h3F, 1'b1, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_strobes(2);
        repeat (10) @(negedge clk_3125);

        // Start glitch
        base = strobe_cnt;
        rx = 1'b0;
        repeat (8) @(negedge clk_3125);
        check("glitch_busy_hi", {8'h0, busy}, 9'h1);
        repeat (2) @(negedge clk_3125);
        rx = 1'b1;
        repeat (60) @(negedge clk_3125);
        check("glitch_busy_lo", {8'h0, busy}, 9'h0);
        check("glitch_no_strobe", 9'(strobe_cnt - base), 9'h0);
        check("glitch_msg_held", {1'b0, rx_msg}, 9'h03F);

        // Framing error followed by a held-low line, then a good frame
        push(8'h3F, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk_3125);
        check("wait_hi_strobes", 9'(strobe_cnt), 9'd3);
        check("wait_hi_busy", {8'h0, busy}, 9'h1);
        rx = 1'b1;
        repeat (20) @(negedge clk_3125);
        check("wait_hi_released", {8'h0, busy}, 9'h0);
        push(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        wait_strobes(4);
        repeat (10) @(negedge clk_3125);

        // Reset during data bit 3 of 0x81
        base = strobe_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        rx = 1'b0;
        repeat (13) @(negedge clk_3125);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk_3125);
        check("midrst_msg",  {1'b0, rx_msg}, 9'h0);
        check("midrst_perr", {8'h0, parity_err}, 9'h0);
        check("midrst_ferr", {8'h0, frame_err}, 9'h0);
        check("midrst_busy", {8'h0, busy}, 9'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk_3125);
        check("midrst_no_strobe", 9'(strobe_cnt - base), 9'h0);
        push(8'h7E, 1'b0, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
        wait_strobes(base + 1);
        repeat (10) @(negedge clk_3125);

        // Back-to-back frames: strobes one full frame apart
        base = strobe_cnt;
        push(8'h00, 1'b0, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, GLITCH);
        send_frame(8'hFF, 1'b0, 1'b1, GLITCH);
        wait_strobes(base + 2);
        gap = (strobe_times.size() >= base + 2) ?
              strobe_times[base + 1] - strobe_times[base] : -1;
        checks++;
        assert (gap == N_BITS * CPB) else begin
            errors++;
            $error("FAIL b2b_gap: observed=%0d expected=%0d", gap, N_BITS * CPB);
        end
        repeat (20) @(negedge clk_3125);
        check("sb_drained", 9'(sb.size()), 9'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
